// File: rtl/jtag_tap_sequencer.sv
// jtag_tap_sequencer: one-command-at-a-time JTAG master for a 1149.1 TAP.
// Issues TLR reset, IR/DR scans and run-test/idle clocks, returning captured TDO bits.
module jtag_tap_sequencer #(
   parameter int unsigned MAX_LEN = 64,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               busy,
   output logic               jtag_tck,
   output logic               jtag_tms,
   output logic               jtag_tdi,
   input  logic               jtag_tdo,
   output logic               jtag_trst
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 7);
   localparam int unsigned PH_W  = $clog2(2 * CLK_DIV);
   localparam int unsigned BIT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [1:0] OP_TLR = 2'd0;
   localparam logic [1:0] OP_IR  = 2'd1;
   localparam logic [1:0] OP_DR  = 2'd2;
   localparam logic [1:0] OP_RUN = 2'd3;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RUN, S_RESP} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [PH_W-1:0]    r_ph;
   logic [CNT_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_len;
   logic [1:0]         r_op;
   logic [MAX_LEN-1:0] r_data;
   logic [MAX_LEN-1:0] r_cap;
   logic               r_tck;
   logic               r_tms;
   logic               r_tdi;
   logic               r_trst;
   logic               r_cmd_ready;
   logic               r_rsp_valid;
   logic               r_busy;

   logic               w_tck_state;
   logic               w_ph_end;
   logic               w_rise;
   logic               w_accept;
   logic               w_len_zero;
   logic               w_idx_last;
   logic               w_tck;
   logic               w_tms;
   logic               w_tdi;
   logic [LEN_W-1:0]   w_len_clamp;
   logic [CNT_W-1:0]   w_len_new;
   logic [BIT_W-1:0]   w_bit;

   assign w_tck_state = (r_state == S_INIT) || (r_state == S_PRE) || (r_state == S_SHIFT) ||
                        (r_state == S_POST) || (r_state == S_RUN);
   assign w_ph_end    = w_tck_state && (r_ph == PH_W'(2 * CLK_DIV - 1));
   assign w_rise      = w_tck_state && (r_ph == PH_W'(CLK_DIV));
   assign w_accept    = (r_state == S_IDLE) && r_cmd_ready && cmd_valid;
   assign w_len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
   assign w_len_new   = CNT_W'(w_len_clamp);
   assign w_len_zero  = (w_len_clamp == '0);
   assign w_bit       = r_idx[BIT_W-1:0];

   // Index of the final TCK period in each clocked state
   always_comb begin
      w_idx_last = 1'b0;
      case (r_state)
         S_INIT:  w_idx_last = (r_idx == CNT_W'(5));
         S_PRE: begin
            case (r_op)
               OP_TLR:  w_idx_last = (r_idx == CNT_W'(5));
               OP_IR:   w_idx_last = (r_idx == CNT_W'(3));
               default: w_idx_last = (r_idx == CNT_W'(2));
            endcase
         end
         S_SHIFT, S_RUN: w_idx_last = (r_idx == CNT_W'(r_len - CNT_W'(1)));
         S_POST:  w_idx_last = (r_idx == CNT_W'(1));
         default: w_idx_last = 1'b0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) r_state <= S_INIT;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:  if (w_ph_end && w_idx_last) w_next = S_IDLE;
         S_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  OP_IR, OP_DR: w_next = w_len_zero ? S_RESP : S_PRE;
                  OP_RUN:       w_next = w_len_zero ? S_RESP : S_RUN;
                  default:      w_next = S_PRE;
               endcase
            end
         end
         S_PRE:   if (w_ph_end && w_idx_last) w_next = (r_op == OP_TLR) ? S_RESP : S_SHIFT;
         S_SHIFT: if (w_ph_end && w_idx_last) w_next = S_POST;
         S_POST:  if (w_ph_end && w_idx_last) w_next = S_RESP;
         S_RUN:   if (w_ph_end && w_idx_last) w_next = S_RESP;
         S_RESP:  if (r_rsp_valid && rsp_ready) w_next = S_IDLE;
         default: w_next = S_INIT;
      endcase
   end

   // Pin values for the current phase; registered one cycle later with the TCK level
   always_comb begin
      w_tck = w_tck_state && (r_ph >= PH_W'(CLK_DIV));
      w_tms = 1'b0;
      w_tdi = 1'b0;
      case (r_state)
         S_INIT: w_tms = (r_idx < CNT_W'(5));
         S_PRE: begin
            case (r_op)
               OP_TLR:  w_tms = (r_idx < CNT_W'(5));
               OP_IR:   w_tms = (r_idx < CNT_W'(2));
               default: w_tms = (r_idx < CNT_W'(1));
            endcase
         end
         S_SHIFT: begin
            w_tms = w_idx_last;
            w_tdi = r_data[0];
         end
         S_POST:  w_tms = (r_idx == '0);
         default: w_tms = 1'b0;
      endcase
   end

   // Phase and period counters restart on every state change
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_ph  <= '0;
         r_idx <= '0;
      end else if ((w_next != r_state) || !w_tck_state) begin
         r_ph  <= '0;
         r_idx <= '0;
      end else if (w_ph_end) begin
         r_ph  <= '0;
         r_idx <= r_idx + CNT_W'(1);
      end else begin
         r_ph  <= r_ph + PH_W'(1);
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_op   <= OP_TLR;
         r_len  <= '0;
         r_data <= '0;
         r_cap  <= '0;
      end else if (w_accept) begin
         r_op   <= cmd_op;
         r_len  <= w_len_new;
         r_data <= cmd_data;
         r_cap  <= '0;
      end else if (r_state == S_SHIFT) begin
         if (w_rise)   r_cap[w_bit] <= jtag_tdo;
         if (w_ph_end) r_data       <= r_data >> 1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_tck       <= 1'b0;
         r_tms       <= 1'b1;
         r_tdi       <= 1'b0;
         r_trst      <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_tck       <= w_tck;
         r_tms       <= w_tms;
         r_tdi       <= w_tdi;
         r_trst      <= 1'b1;
         r_cmd_ready <= (w_next == S_IDLE);
         r_rsp_valid <= (r_state == S_RESP) && (w_next == S_RESP);
         r_busy      <= (w_next != S_IDLE);
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_cap;
   assign busy      = r_busy;
   assign jtag_tck  = r_tck;
   assign jtag_tms  = r_tms;
   assign jtag_tdi  = r_tdi;
   assign jtag_trst = r_trst;

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Directed bench for jtag_tap_sequencer with a behavioural 1149.1 TAP
// (5-bit IR, IDCODE 0x249511C3 at IR=0x01, BYPASS otherwise).
module tb_jtag_tap_sequencer;

   localparam logic [1:0]  OP_TLR    = 2'd0;
   localparam logic [1:0]  OP_IR     = 2'd1;
   localparam logic [1:0]  OP_DR     = 2'd2;
   localparam logic [1:0]  OP_RUN    = 2'd3;
   localparam logic [4:0]  IR_IDCODE = 5'h01;
   localparam logic [31:0] IDCODE    = 32'h249511C3;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [6:0]  cmd_len;
   logic [63:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_data;
   logic        busy;
   logic        jtag_tck;
   logic        jtag_tms;
   logic        jtag_tdi;
   logic        jtag_tdo;
   logic        jtag_trst;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned base;
   int unsigned lat;
   logic [63:0] rsp;

   jtag_tap_sequencer #(.MAX_LEN(64), .CLK_DIV(4)) dut (
      .clk_in(clk_in), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
      .jtag_tdo(jtag_tdo), .jtag_trst(jtag_trst)
   );

   always #5 clk_in = ~clk_in;

   // Rising-edge log of TMS/TDI as the TAP sees them
   int unsigned tck_edges = 0;
   logic        tms_log [0:1023];
   logic        tdi_log [0:1023];
   always @(posedge jtag_tck) begin
      if (tck_edges < 1024) begin
         tms_log[tck_edges] <= jtag_tms;
         tdi_log[tck_edges] <= jtag_tdi;
      end
      tck_edges <= tck_edges + 1;
   end

   typedef enum logic [3:0] {T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR,
                             T_UPDR, T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR} tap_t;
   tap_t        tap_st = T_TLR;
   logic [4:0]  ir     = IR_IDCODE;
   logic [4:0]  ir_sh  = '0;
   logic [31:0] dr_sh  = '0;
   logic        byp    = 1'b0;
   logic        tap_tdo = 1'b0;
   assign jtag_tdo = tap_tdo;

   function automatic tap_t tap_next(input tap_t s, input logic tms);
      case (s)
         T_TLR:   return tms ? T_TLR   : T_RTI;
         T_RTI:   return tms ? T_SELDR : T_RTI;
         T_SELDR: return tms ? T_SELIR : T_CAPDR;
         T_CAPDR: return tms ? T_EX1DR : T_SHDR;
         T_SHDR:  return tms ? T_EX1DR : T_SHDR;
         T_EX1DR: return tms ? T_UPDR  : T_PADR;
         T_PADR:  return tms ? T_EX2DR : T_PADR;
         T_EX2DR: return tms ? T_UPDR  : T_SHDR;
         T_UPDR:  return tms ? T_SELDR : T_RTI;
         T_SELIR: return tms ? T_TLR   : T_CAPIR;
         T_CAPIR: return tms ? T_EX1IR : T_SHIR;
         T_SHIR:  return tms ? T_EX1IR : T_SHIR;
         T_EX1IR: return tms ? T_UPIR  : T_PAIR;
         T_PAIR:  return tms ? T_EX2IR : T_PAIR;
         T_EX2IR: return tms ? T_UPIR  : T_SHIR;
         default: return tms ? T_SELDR : T_RTI;
      endcase
   endfunction

   always @(posedge jtag_tck or negedge jtag_trst) begin
      if (!jtag_trst) begin
         tap_st <= T_TLR;
         ir     <= IR_IDCODE;
      end else begin
         case (tap_st)
            T_TLR:   ir <= IR_IDCODE;
            T_CAPDR: begin dr_sh <= IDCODE; byp <= 1'b0; end
            T_SHDR:  begin dr_sh <= {jtag_tdi, dr_sh[31:1]}; byp <= jtag_tdi; end
            T_CAPIR: ir_sh <= 5'h01;
            T_SHIR:  ir_sh <= {jtag_tdi, ir_sh[4:1]};
            T_UPIR:  ir <= ir_sh;
            default: ;
         endcase
         tap_st <= tap_next(tap_st, jtag_tms);
      end
   end

   always @(negedge jtag_tck) begin
      if (tap_st == T_SHDR)      tap_tdo <= (ir == IR_IDCODE) ? dr_sh[0] : byp;
      else if (tap_st == T_SHIR) tap_tdo <= ir_sh[0];
      else                       tap_tdo <= 1'b0;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] log_bits(input bit sel_tdi, input int unsigned start,
                                            input int unsigned n);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 64; k++) begin
         if (k < n && (start + k) < 1024) v[k] = sel_tdi ? tdi_log[start + k] : tms_log[start + k];
      end
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [6:0] len, input logic [63:0] data);
      int unsigned n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 500) begin tick(); n++; end
      check("cmd_ready_before_send", 64'(cmd_ready), 64'd1);
      cmd_op    = op;
      cmd_len   = len;
      cmd_data  = data;
      cmd_valid = 1'b1;
      base      = tck_edges;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 3000) begin tick(); lat++; end
      rsp = rsp_data;
   endtask

   task automatic ack();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // Release reset and verify the INIT walk into Run-Test/Idle
   task automatic release_and_check_init(input string tag);
      logic saw_rsp;
      saw_rsp = 1'b0;
      reset   = 1'b0;
      base    = tck_edges;
      tick();
      check({tag, "_trst"}, 64'(jtag_trst), 64'd1);
      for (int i = 0; i < 46; i++) begin
         tick();
         if (rsp_valid !== 1'b0) saw_rsp = 1'b1;
      end
      check({tag, "_ready_early"}, 64'(cmd_ready), 64'd0);
      tick();
      check({tag, "_ready"}, 64'(cmd_ready), 64'd1);
      check({tag, "_edges"}, 64'(tck_edges - base), 64'd6);
      check({tag, "_tms"}, log_bits(1'b0, base, 6), 64'h1F);
      check({tag, "_no_rsp"}, 64'(saw_rsp), 64'd0);
   endtask

   initial begin
      logic        ok;
      logic [63:0] d;
      int unsigned e;
      int unsigned n;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_len   = '0;
      cmd_data  = '0;
      rsp_ready = 1'b0;
      repeat (4) tick();
      check("reset_pins", 64'({jtag_tck, jtag_tms, jtag_tdi, jtag_trst}), 64'b0100);
      check("reset_hs", 64'({cmd_ready, rsp_valid, busy}), 64'b001);
      check("reset_rsp_data", rsp_data, 64'd0);
      release_and_check_init("init");

      // IR scan of IDCODE instruction
      send(OP_IR, 7'd5, 64'h01);
      check("ir_ready_low", 64'(cmd_ready), 64'd0);
      check("ir_busy", 64'(busy), 64'd1);
      wait_rsp();
      check("ir_lat", 64'(lat), 64'd89);
      check("ir_rsp", rsp, 64'h01);
      check("ir_edges", 64'(tck_edges - base), 64'd11);
      check("ir_tms", log_bits(1'b0, base, 11), 64'h303);
      check("ir_tdi", log_bits(1'b1, base + 4, 5), 64'h01);
      ack();
      check("ir_ack", 64'({rsp_valid, cmd_ready, busy}), 64'b010);

      send(OP_DR, 7'd32, 64'd0);
      wait_rsp();
      check("idcode_lat", 64'(lat), 64'd297);
      check("idcode_rsp", rsp, 64'(IDCODE));
      check("idcode_edges", 64'(tck_edges - base), 64'd37);
      check("idcode_shift_tms", log_bits(1'b0, base + 3, 32), 64'h8000_0000);
      ack();

      send(OP_DR, 7'd0, 64'hFFFF);
      wait_rsp();
      check("len0_lat_le2", 64'(lat <= 2), 64'd1);
      check("len0_rsp", rsp, 64'd0);
      check("len0_edges", 64'(tck_edges - base), 64'd0);
      ack();

      send(OP_IR, 7'd5, 64'h1F);
      wait_rsp();
      check("bypass_ir_rsp", rsp, 64'h01);
      ack();

      send(OP_DR, 7'd1, 64'h1);
      wait_rsp();
      check("bypass1_rsp", rsp, 64'd0);
      check("bypass1_edges", 64'(tck_edges - base), 64'd6);
      check("bypass1_tms", log_bits(1'b0, base, 6), 64'h19);
      ack();

      // Oversized length is clamped to 64 bits through the 1-bit bypass register
      d = 64'hA5A5_5A5A_0F0F_F0F0;
      send(OP_DR, 7'd100, d);
      wait_rsp();
      check("len100_lat", 64'(lat), 64'd553);
      check("len100_edges", 64'(tck_edges - base), 64'd69);
      check("len100_rsp", rsp, {d[62:0], 1'b0});
      ack();

      send(OP_RUN, 7'd3, 64'd0);
      wait_rsp();
      check("run_lat", 64'(lat), 64'd25);
      check("run_edges", 64'(tck_edges - base), 64'd3);
      check("run_tms", log_bits(1'b0, base, 3), 64'd0);
      check("run_rsp", rsp, 64'd0);
      ack();

      send(OP_TLR, 7'd0, 64'd0);
      wait_rsp();
      check("tlr_lat", 64'(lat), 64'd49);
      check("tlr_edges", 64'(tck_edges - base), 64'd6);
      check("tlr_tms", log_bits(1'b0, base, 6), 64'h1F);
      check("tlr_rsp", rsp, 64'd0);
      ack();

      // Backpressure: hold the response, poke cmd_valid, expect nothing to move
      send(OP_DR, 7'd32, 64'd0);
      wait_rsp();
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_after_tlr", rsp, 64'(IDCODE));
      e  = tck_edges;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cmd_op    = OP_RUN;
         cmd_len   = 7'd5;
         cmd_valid = (i == 5);
         tick();
         if (rsp_valid !== 1'b1 || rsp_data !== rsp || cmd_ready !== 1'b0 ||
             jtag_tck !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      end
      cmd_valid = 1'b0;
      check("bp_stable", 64'(ok), 64'd1);
      check("bp_no_tck", 64'(tck_edges - e), 64'd0);
      ack();
      repeat (20) tick();
      check("bp_no_accept_edges", 64'(tck_edges - e), 64'd0);
      check("bp_idle", 64'({cmd_ready, busy, rsp_valid}), 64'b100);

      // Reset at the 10th TCK of a DR scan
      send(OP_DR, 7'd32, 64'd0);
      n = 0;
      while ((tck_edges - base) < 10 && n < 200) begin tick(); n++; end
      check("mid_edge10", 64'(tck_edges - base), 64'd10);
      reset = 1'b1;
      tick();
      check("mid_reset_pins", 64'({jtag_tck, jtag_tms, jtag_trst}), 64'b010);
      check("mid_reset_hs", 64'({rsp_valid, cmd_ready, busy}), 64'b001);
      repeat (3) tick();
      check("mid_reset_rsp_data", rsp_data, 64'd0);
      release_and_check_init("reinit");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
